// File: rtl/dds_phase_gen_if.sv
// Host/ROM/converter-facing bus of the DDS phase front end.
// master = host side (drives load and tuning controls), slave = dds_phase_gen.
interface dds_phase_gen_if #(
    parameter int unsigned ACC_W = 32
);
    logic             load_start;
    logic             load_valid;
    logic [47:0]      load_data;
    logic             load_ready;
    logic             run_en;
    logic             ftw_wr;
    logic [ACC_W-1:0] ftw_in;
    logic [15:0]      poff_in;
    logic             busy;
    logic             cen;
    logic             wen;
    logic [5:0]       index_wri;
    logic [47:0]      D;
    logic             wen_in;
    logic [2:0]       index_qua;
    logic [5:0]       index_rea;
    logic [6:0]       index_cor;

    modport master (
        output load_start, load_valid, load_data, run_en, ftw_wr, ftw_in, poff_in,
        input  load_ready, busy, cen, wen, index_wri, D, wen_in,
               index_qua, index_rea, index_cor
    );

    modport slave (
        input  load_start, load_valid, load_data, run_en, ftw_wr, ftw_in, poff_in,
        output load_ready, busy, cen, wen, index_wri, D, wen_in,
               index_qua, index_rea, index_cor
    );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS front end: loads the 64x48 coarse ROM, then runs the phase accumulator and
// splits the truncated phase into octant/ROM index/residual. Option: PHASE_DITHER_EN.
module dds_phase_gen #(
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned ROM_DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    dds_phase_gen_if.slave   bus
);
    localparam int unsigned PH_W   = 16;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DATA_W = 48;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, ftw_q, ftw_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d, wri_q, wri_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               wen_q, wen_d, cen_q, cen_d, wen_in_q, wen_in_d;
    logic               busy_q, busy_d, ready_q, ready_d;
    logic [2:0]         qua_q, qua_d;
    logic [5:0]         rea_q, rea_d;
    logic [6:0]         cor_q, cor_d;
    logic [PH_W-1:0]    ph_c;
    logic               step_c;
    logic               accept_c;

`ifdef PHASE_DITHER_EN
    localparam int unsigned DW = ((ACC_W - PH_W) > 16) ? 16 : (ACC_W - PH_W);
    localparam int unsigned SH = ACC_W - PH_W - DW;
    localparam logic [15:0] DMASK = 16'((32'd1 << DW) - 32'd1);

    logic [15:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] dith_sum_c;

    // Dither lands just below the truncation point; its carry ripples into ph.
    always_comb begin
        dith_sum_c = acc_q + (ACC_W'(lfsr_q & DMASK) << SH);
        ph_c       = dith_sum_c[ACC_W-1 -: PH_W] + bus.poff_in;
        lfsr_d     = lfsr_q;
        if (step_c)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    always_comb begin
        ph_c = acc_q[ACC_W-1 -: PH_W] + bus.poff_in;
    end
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ftw_d    = bus.ftw_wr ? bus.ftw_in : ftw_q;
        cnt_d    = cnt_q;
        wri_d    = wri_q;
        data_d   = data_q;
        wen_d    = 1'b0;
        cen_d    = 1'b0;
        wen_in_d = 1'b0;
        qua_d    = qua_q;
        rea_d    = rea_q;
        cor_d    = cor_q;
        step_c   = 1'b0;
        accept_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                end else if (bus.run_en) begin
                    state_d = RUN;
                    step_c  = 1'b1;
                end
            end
            LOAD: begin
                accept_c = bus.load_valid & ready_q;
                if (accept_c) begin
                    data_d = bus.load_data;
                    wri_d  = cnt_q;
                    wen_d  = 1'b1;
                    cen_d  = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                if (bus.load_start)  state_d = LOAD;
                else if (bus.run_en) step_c  = 1'b1;
                else                 state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Sample carries the pre-update accumulator; the step uses the old ftw.
        if (step_c) begin
            acc_d    = acc_q + ftw_q;
            wen_in_d = 1'b1;
            cen_d    = 1'b1;
            qua_d    = ph_c[15:13];
            rea_d    = ph_c[12:7];
            cor_d    = ph_c[6:0];
        end

        busy_d  = (state_d == LOAD);
        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            ftw_q    <= '0;
            cnt_q    <= '0;
            wri_q    <= '0;
            data_q   <= '0;
            wen_q    <= 1'b0;
            cen_q    <= 1'b0;
            wen_in_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            qua_q    <= '0;
            rea_q    <= '0;
            cor_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ftw_q    <= ftw_d;
            cnt_q    <= cnt_d;
            wri_q    <= wri_d;
            data_q   <= data_d;
            wen_q    <= wen_d;
            cen_q    <= cen_d;
            wen_in_q <= wen_in_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            qua_q    <= qua_d;
            rea_q    <= rea_d;
            cor_q    <= cor_d;
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.cen        = cen_q;
    assign bus.wen        = wen_q;
    assign bus.index_wri  = wri_q;
    assign bus.D          = data_q;
    assign bus.wen_in     = wen_in_q;
    assign bus.index_qua  = qua_q;
    assign bus.index_rea  = rea_q;
    assign bus.index_cor  = cor_q;
endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen: stimulus pushes expected ROM writes and
// phase samples; a negedge monitor pops and compares whenever wen / wen_in fire.
module tb_dds_phase_gen;
    typedef struct packed {
        logic [5:0]  addr;
        logic [47:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   passes;
    int   total;
    wr_t         exp_wr_q[$];
    logic [15:0] exp_ph_q[$];

    dds_phase_gen_if #(.ACC_W(32)) bus ();

    dds_phase_gen #(.ACC_W(32), .ROM_DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    // Monitor: compares every ROM write and every phase sample against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.wen || bus.wen_in)
                check("wen_wen_in_exclusive", 64'(bus.wen & bus.wen_in), 64'd0);
            if (bus.wen) begin
                check("cen_on_write", 64'(bus.cen), 64'd1);
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 64'(bus.wen), 64'd0);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check("index_wri", 64'(bus.index_wri), 64'(e.addr));
                    check("rom_data", 64'(bus.D), 64'(e.data));
                end
            end
            if (bus.wen_in) begin
                if (exp_ph_q.size() == 0) begin
                    check("unexpected_sample", 64'(bus.wen_in), 64'd0);
                end else begin
                    logic [15:0] p;
                    p = exp_ph_q.pop_front();
                    check("index_qua", 64'(bus.index_qua), 64'(p[15:13]));
                    check("index_rea", 64'(bus.index_rea), 64'(p[12:7]));
                    check("index_cor", 64'(bus.index_cor), 64'(p[6:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.run_en     = 1'b0;
        bus.ftw_wr     = 1'b0;
        bus.ftw_in     = '0;
        bus.poff_in    = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic push_word(input int i);
        wr_t w;
        bus.load_valid = 1'b1;
        bus.load_data  = 48'(i * 3);
        w.addr = 6'(i);
        w.data = 48'(i * 3);
        exp_wr_q.push_back(w);
    endtask

    task automatic do_load(input bit stall);
        start_load();
        for (int i = 0; i < 64; i++) begin
            push_word(i);
            if (i == 63) check("busy_before_last", 64'(bus.busy), 64'd1);
            tick();
            if (stall) begin
                bus.load_valid = 1'b0;
                tick();
            end
        end
        bus.load_valid = 1'b0;
        check("busy_after_last", 64'(bus.busy), 64'd0);
        check("ready_after_last", 64'(bus.load_ready), 64'd0);
        tick();
        tick();
        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    endtask

    // Four hand-computed phases packed MSB-first; n of them are expected.
    task automatic run_tbl(input logic [31:0] ftw, input logic [15:0] poff,
                           input int n, input logic [63:0] phs);
        do_reset();
        bus.ftw_wr  = 1'b1;
        bus.ftw_in  = ftw;
        bus.poff_in = poff;
        tick();
        bus.ftw_wr = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.run_en = 1'b1;
            exp_ph_q.push_back(phs[63-16*i -: 16]);
            tick();
        end
        bus.run_en = 1'b0;
        repeat (3) tick();
        check("ph_queue_drained", 64'(exp_ph_q.size()), 64'd0);
        check("wen_in_idle", 64'(bus.wen_in), 64'd0);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        do_reset();
        reset = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.load_ready), 64'd0);
        check("rst_wen_cen_wen_in", 64'({bus.wen, bus.cen, bus.wen_in}), 64'd0);
        check("rst_index", 64'({bus.index_qua, bus.index_rea, bus.index_cor, bus.index_wri}), 64'd0);
        check("rst_D", 64'(bus.D), 64'd0);
        reset = 1'b1;
        tick();

        do_load(1'b0);
        do_load(1'b1);

        run_tbl(32'h0100_0000, 16'h0000, 4, {16'h0000, 16'h0100, 16'h0200, 16'h0300});
        check("hold_qua", 64'(bus.index_qua), 64'd0);
        check("hold_rea", 64'(bus.index_rea), 64'd6);
        check("hold_cor", 64'(bus.index_cor), 64'd0);

        run_tbl(32'hF000_0000, 16'h0000, 3, {16'h0000, 16'hF000, 16'hE000, 16'h0000});
        check("hold_qua_wrap", 64'(bus.index_qua), 64'd7);
        run_tbl(32'hF000_0000, 16'h2000, 3, {16'h2000, 16'h1000, 16'h0000, 16'h0000});

        // ftw_wr coincident with a step: that step still uses the old ftw.
        do_reset();
        bus.ftw_wr = 1'b1;
        bus.ftw_in = 32'h0100_0000;
        tick();
        bus.ftw_wr = 1'b0;
        bus.run_en = 1'b1;
        exp_ph_q.push_back(16'h0000);
        tick();
        bus.ftw_wr = 1'b1;
        bus.ftw_in = 32'h0200_0000;
        exp_ph_q.push_back(16'h0100);
        tick();
        bus.ftw_wr = 1'b0;
        exp_ph_q.push_back(16'h0200);
        tick();
        exp_ph_q.push_back(16'h0400);
        tick();
        bus.run_en = 1'b0;
        repeat (3) tick();
        check("ftw_queue_drained", 64'(exp_ph_q.size()), 64'd0);

        // Reset in the middle of a load, then a clean reload from index 0.
        do_reset();
        start_load();
        for (int i = 0; i < 20; i++) begin
            push_word(i);
            tick();
        end
        bus.load_valid = 1'b1;
        bus.load_data  = 48'd60;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_wen_cen", 64'({bus.wen, bus.cen}), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_index_D", 64'({bus.index_wri, bus.D}), 64'd0);
        check("midrst_queue", 64'(exp_wr_q.size()), 64'd0);
        bus.load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_load(1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end
endmodule
